ram_arbiter: RTL

Two-port arbiter that shares the single-ported data RAM between the CPU decoder (port 0) and a second requester such as a debug/loader engine (port 1). It sits between the requesters and the RAM's address, write-enable, write-data and read-data pins, replacing the direct GPR-to-RAM address path. It serialises accesses through a small state machine, grants round-robin under contention, and returns a one-cycle acknowledge with read data.

---
 rtl/ram_arbiter_if.sv | 36 +++
 rtl/ram_arbiter.sv | 116 +++++++++++
 2 files changed

// File: rtl/ram_arbiter_if.sv
// rtl/ram_arbiter_if.sv - requester and RAM-pin bundle for the two-port RAM arbiter
interface ram_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
);
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              ack0;
    logic              ack1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic              busy;
    logic [1:0]        grant;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_w_enable;
    logic [DATA_W-1:0] ram_w_data;
    logic [DATA_W-1:0] ram_r_data;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_r_data,
        output ack0, ack1, rdata0, rdata1, busy, grant,
               ram_addr, ram_w_enable, ram_w_data
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_r_data,
        input  ack0, ack1, rdata0, rdata1, busy, grant,
               ram_addr, ram_w_enable, ram_w_data
    );
endinterface

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - round-robin arbiter sharing one single-ported RAM between two requesters
module ram_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    ram_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [2:0] CNT_LOAD = 3'(RD_LAT - 1);

    state_t            state;
    state_t            state_nx;
    logic              owner;
    logic              owner_nx;
    logic              last_grant;
    logic              last_grant_nx;
    logic              lat_we;
    logic              lat_we_nx;
    logic [ADDR_W-1:0] lat_addr;
    logic [ADDR_W-1:0] lat_addr_nx;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] lat_wdata_nx;
    logic [2:0]        cnt;
    logic [2:0]        cnt_nx;
    logic              winner;
    logic              in_access;
    logic              in_done;

    // Under contention the port that did not win last time goes first.
    always_comb begin
        winner = bus.req1;
        if (bus.req0 && bus.req1) begin
            winner = ~last_grant;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            cnt        <= 3'd0;
        end else begin
            state      <= state_nx;
            owner      <= owner_nx;
            last_grant <= last_grant_nx;
            lat_we     <= lat_we_nx;
            lat_addr   <= lat_addr_nx;
            lat_wdata  <= lat_wdata_nx;
            cnt        <= cnt_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        owner_nx      = owner;
        last_grant_nx = last_grant;
        lat_we_nx     = lat_we;
        lat_addr_nx   = lat_addr;
        lat_wdata_nx  = lat_wdata;
        cnt_nx        = cnt;
        case (state)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    state_nx      = ACCESS;
                    owner_nx      = winner;
                    last_grant_nx = winner;
                    lat_we_nx     = winner ? bus.we1    : bus.we0;
                    lat_addr_nx   = winner ? bus.addr1  : bus.addr0;
                    lat_wdata_nx  = winner ? bus.wdata1 : bus.wdata0;
                    cnt_nx        = lat_we_nx ? 3'd0 : CNT_LOAD;
                end
            end
            ACCESS: begin
                // Writes take one cycle; reads hold the address for RD_LAT cycles.
                if (lat_we || cnt == 3'd0) begin
                    state_nx = DONE;
                end else begin
                    cnt_nx = cnt - 3'd1;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign in_access = (state == ACCESS);
    assign in_done   = (state == DONE);

    // All RAM drive is decoded from registered state only.
    assign bus.busy         = (state != IDLE);
    assign bus.grant        = (state == IDLE) ? 2'b00 : (owner ? 2'b10 : 2'b01);
    assign bus.ram_addr     = (state == IDLE) ? '0 : lat_addr;
    assign bus.ram_w_enable = in_access & lat_we;
    assign bus.ram_w_data   = (in_access & lat_we) ? lat_wdata : '0;

    assign bus.ack0   = in_done & ~owner;
    assign bus.ack1   = in_done & owner;
    assign bus.rdata0 = (in_done & ~owner & ~lat_we) ? bus.ram_r_data : '0;
    assign bus.rdata1 = (in_done & owner & ~lat_we)  ? bus.ram_r_data : '0;
endmodule
